// File: rtl/router_pkt_tx_if.sv
`default_nettype none
//==============================================================================
// router_pkt_tx_if : request, payload-buffer and router link of router_pkt_tx
// Rev 1.0
//==============================================================================
interface router_pkt_tx_if #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 6
);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              ready;
  logic              done;
  logic              err;
  logic [7:0]        pl_data;
  logic              pl_rd;
  logic              busy;
  logic [7:0]        data_in;
  logic              pkt_valid;

  modport master (
    input  start, addr, len, pl_data, busy,
    output ready, done, err, pl_rd, data_in, pkt_valid
  );

  modport slave (
    output start, addr, len, pl_data, busy,
    input  ready, done, err, pl_rd, data_in, pkt_valid
  );
endinterface
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
//==============================================================================
// router_pkt_tx : serialises header/payload/parity into router_1x3 under busy.
// Option ROUTER_PKT_TX_LFSR_EN sources payload from an internal LFSR.  Rev 1.0
//==============================================================================
module router_pkt_tx #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 6
) (
  input  logic            clock,
  input  logic            resetn,
  router_pkt_tx_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_PAR  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_BAD = '1;

  logic [1:0]       state_q, state_d;
  logic [7:0]       data_in_q, data_in_d;
  logic [7:0]       parity_q, parity_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;

  logic [LEN_W:0]   count_inc;
  logic             accept;
  logic             more;
  logic             pop;
  logic             start_ok;
  logic             start_bad;
  logic [7:0]       hdr_byte;
  logic [7:0]       pl_byte;

  always_comb begin
    count_inc = {1'b0, count_q} + {{LEN_W{1'b0}}, 1'b1};
    accept    = (state_q != S_IDLE) && !bus.busy;
    // "more" means another payload byte must be pulled at this accept edge
    more      = 1'b0;
    if (state_q == S_HDR) begin
      more = (len_q != '0);
    end else if (state_q == S_PAY) begin
      more = (count_inc < {1'b0, len_q});
    end
    pop       = accept && more;
    start_ok  = (state_q == S_IDLE) && bus.start && (bus.addr != ADDR_BAD);
    start_bad = (state_q == S_IDLE) && bus.start && (bus.addr == ADDR_BAD);
    hdr_byte  = 8'({bus.len, bus.addr});
  end

`ifdef ROUTER_PKT_TX_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       unused_pl_data;

  assign unused_pl_data = ^bus.pl_data;
  assign pl_byte        = lfsr_q;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1
  always_comb begin
    lfsr_d = lfsr_q;
    if (pop) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign pl_byte = bus.pl_data;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_HDR;
      S_HDR:  if (accept)   state_d = more ? S_PAY : S_PAR;
      S_PAY:  if (accept && !more) state_d = S_PAR;
      S_PAR:  if (accept)   state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_in_d   = data_in_q;
    parity_d    = parity_q;
    pkt_valid_d = pkt_valid_q;
    len_d       = len_q;
    count_d     = count_q;
    done_d      = 1'b0;
    err_d       = start_bad;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          len_d       = bus.len;
          data_in_d   = hdr_byte;
          parity_d    = hdr_byte;
          count_d     = '0;
          pkt_valid_d = 1'b1;
        end
      end
      S_HDR, S_PAY: begin
        if (accept) begin
          if (state_q == S_PAY) begin
            count_d = count_inc[LEN_W-1:0];
          end
          if (more) begin
            data_in_d = pl_byte;
            parity_d  = parity_q ^ pl_byte;
          end else begin
            data_in_d   = parity_q;
            pkt_valid_d = 1'b0;
          end
        end
      end
      S_PAR: begin
        if (accept) begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_in_q   <= 8'h00;
      parity_q    <= 8'h00;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      count_q     <= '0;
    end else begin
      data_in_q   <= data_in_d;
      parity_q    <= parity_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      len_q       <= len_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    bus.ready     = (state_q == S_IDLE);
`ifdef ROUTER_PKT_TX_LFSR_EN
    bus.pl_rd     = 1'b0;
`else
    bus.pl_rd     = pop;
`endif
    bus.data_in   = data_in_q;
    bus.pkt_valid = pkt_valid_q;
    bus.done      = done_q;
    bus.err       = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
//==============================================================================
// tb_router_pkt_tx : scoreboard bench for router_pkt_tx
// Rev 1.0
//==============================================================================
module tb_router_pkt_tx;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  router_pkt_tx_if #(.ADDR_W(2), .LEN_W(6)) bus ();

  router_pkt_tx #(.ADDR_W(2), .LEN_W(6)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] val;
    bit         is_par;
    int         len;
  } exp_t;

  exp_t       exp_q[$];
  int         start_q[$];
  int         err_q[$];
  logic [7:0] up_q[$];

  int cyc       = 0;
  int n_cmp     = 0;
  int n_bad     = 0;
  int busy_mode = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Upstream FWFT buffer: pop on edges where pl_rd was high; junk when empty
  initial begin
    bit p;
    bus.pl_data = 8'h00;
    forever begin
      @(negedge clock);
      p = bus.pl_rd;
      @(posedge clock);
      #2;
      if (!resetn) begin
        up_q.delete();
      end else if (p && up_q.size() != 0) begin
        void'(up_q.pop_front());
      end
      bus.pl_data = (up_q.size() != 0) ? up_q[0] : 8'($urandom);
    end
  end

  // Monitor: compares everything the router would see against the scoreboard
  initial begin
    bit   in_pkt    = 0;
    bit   done_pend = 0;
    int   held = 0, bcnt = 0, btot = 0, pcyc = 0, pops = 0;
    int   s;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        check("rst_data_in", {24'd0, bus.data_in}, 32'd0);
        check("rst_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_pl_rd", {31'd0, bus.pl_rd}, 32'd0);
        exp_q.delete();
        start_q.delete();
        err_q.delete();
        in_pkt = 0; done_pend = 0;
        held = 0; bcnt = 0; btot = 0; pcyc = 0; pops = 0;
        continue;
      end
      if (err_q.size() != 0 && err_q[0] == cyc) begin
        check("err_pulse", {31'd0, bus.err}, 32'd1);
        void'(err_q.pop_front());
      end else begin
        check("err_idle", {31'd0, bus.err}, 32'd0);
      end
      if (bus.pkt_valid && !in_pkt) begin
        in_pkt = 1;
        if (start_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hdr_start: header at cycle %0d, required no packet", cyc);
        end else begin
          s = start_q.pop_front();
          check("hdr_latency", cyc, s);
        end
      end
      check("ready", {31'd0, bus.ready}, {31'd0, !in_pkt});
      check("done", {31'd0, bus.done}, {31'd0, done_pend});
      done_pend = 0;
      if (bus.pl_rd) pops++;
      if (in_pkt) begin
        pcyc++;
        held++;
        if (bus.busy) begin
          bcnt++;
          btot++;
        end else if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL byte: got %0h, required nothing (cycle %0d)", bus.data_in, cyc);
          in_pkt = 0;
        end else begin
          e = exp_q.pop_front();
          check("byte", {24'd0, bus.data_in}, {24'd0, e.val});
          check("framing", {31'd0, bus.pkt_valid}, {31'd0, !e.is_par});
          check("hold", held, bcnt + 1);
          held = 0; bcnt = 0;
          if (e.is_par) begin
            check("pops", pops, e.len);
            check("duration", pcyc, e.len + 2 + btot);
            pcyc = 0; btot = 0; pops = 0;
            in_pkt = 0; done_pend = 1;
          end
        end
      end
    end
  end

  // Driver helpers; every call starts and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge clock);
    #1;
    if (busy_mode == 0) bus.busy = 1'b0;
    else if (busy_mode == 1) bus.busy = ($urandom_range(0, 3) == 0);
    if (busy_mode == 1 && !bus.ready) begin
      bus.start = 1'($urandom);
      bus.addr  = 2'($urandom);
      bus.len   = 6'($urandom);
    end else begin
      bus.start = 1'b0;
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l, input logic [7:0] pl[$]);
    int         n = 0;
    logic [7:0] hdr, par;
    exp_t       e;
    while (!bus.ready && n < 300) begin
      tick();
      n++;
    end
    if (!bus.ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_wait: ready got 0, required 1 (cycle %0d)", cyc);
      return;
    end
    bus.start = 1'b1;
    bus.addr  = a;
    bus.len   = l;
    if (a == 2'b11) begin
      err_q.push_back(cyc + 1);
    end else begin
      hdr = {l, a};
      par = hdr;
      e.val = hdr; e.is_par = 0; e.len = l;
      exp_q.push_back(e);
      for (int i = 0; i < int'(l); i++) begin
        up_q.push_back(pl[i]);
        par   = par ^ pl[i];
        e.val = pl[i];
        exp_q.push_back(e);
      end
      e.val = par; e.is_par = 1;
      exp_q.push_back(e);
      start_q.push_back(cyc + 1);
    end
    tick();
  endtask

  task automatic send_rand(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] pl[$];
    for (int i = 0; i < int'(l); i++) pl.push_back(8'($urandom));
    send(a, l, pl);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [1:0] a;
    logic [5:0] l;
    int         n;
    bus.start = 1'b0;
    bus.addr  = 2'b00;
    bus.len   = 6'd0;
    bus.busy  = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    tick();

    busy_mode = 0;
    pl = '{8'h11, 8'h22, 8'h33};
    send(2'd0, 6'd3, pl);

    // Payload byte 5 held by three busy cycles
    busy_mode = 2;
    bus.busy  = 1'b0;
    send_rand(2'd2, 6'd10);
    repeat (5) tick();
    bus.busy = 1'b1;
    repeat (3) tick();
    bus.busy = 1'b0;
    busy_mode = 0;

    send_rand(2'd3, 6'd5);
    send_rand(2'd1, 6'd0);

    // Reset while payload byte 4 is on data_in
    send_rand(2'd0, 6'd20);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    send_rand(2'd0, 6'd2);

    // Back-to-back: second start lands on the done cycle
    send_rand(2'd2, 6'd4);
    send_rand(2'd1, 6'd3);

    busy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0:       l = 6'd0;
        1:       l = 6'd63;
        default: l = 6'($urandom_range(1, 24));
      endcase
      send_rand(a, l);
    end

    busy_mode = 0;
    n = 0;
    while ((exp_q.size() != 0 || !bus.ready) && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("exp_left", exp_q.size(), 0);
    check("start_left", start_q.size(), 0);
    check("err_left", err_q.size(), 0);
    check("payload_left", up_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
